// File: rtl/bus_memory_wait.sv
// bus_memory_wait: parametrised single-port synchronous RAM for the shared
// system bus, with programmable wait states, a ready handshake, a post-reset
// clear sweep and a tri-state read-data driver.
//
// Optional feature macro: BUS_MEMORY_PARITY_EN (per-word even parity plus a
// parity_err output port).
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   address     word address, sampled on accept
//   read_write  1 = write, 0 = read, sampled on accept
//   enable      access request (accepted when ready = 1)
//   output_en   drives data_out when high
//   data_in     write data, sampled on accept
//   data_out    read-data register when output_en = 1, else high-Z
//   ready       high = idle and able to accept a request
//   parity_err  (parity build only) one-cycle pulse after a read whose stored
//               parity does not match the stored data
module bus_memory_wait #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read_write,
    input  logic                  enable,
    input  logic                  output_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef BUS_MEMORY_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  ready
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WCNT_W = 8;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
    logic                    lat_wr_q, lat_wr_d;
    logic [DATA_WIDTH-1:0]   lat_data_q, lat_data_d;
    logic                    ready_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic                    clr_we;
    logic                    acc_go;
    logic                    acc_wr;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_data;
    logic                    acc_in_range;
    logic [IDX_W-1:0]        acc_idx;
    logic                    mem_we;
    logic                    rd_go;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
`ifdef BUS_MEMORY_PARITY_EN
    logic                    mem_par [DEPTH];
`endif

    // Next-state and access decode; the access either comes straight from the
    // bus (zero wait states) or from the latched request at the end of WAIT.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lat_addr_d = lat_addr_q;
        lat_wr_d   = lat_wr_q;
        lat_data_d = lat_data_q;
        clr_we     = 1'b0;
        acc_go     = 1'b0;
        acc_wr     = lat_wr_q;
        acc_addr   = lat_addr_q;
        acc_data   = lat_data_q;

        case (state_q)
            S_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (enable) begin
                    lat_addr_d = address;
                    lat_wr_d   = read_write;
                    lat_data_d = data_in;
                    if (WAIT_STATES == 0) begin
                        acc_go   = 1'b1;
                        acc_wr   = read_write;
                        acc_addr = address;
                        acc_data = data_in;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WCNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    acc_go  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // Out-of-range addresses drop writes and read back zero.
    assign acc_in_range = (64'(acc_addr) < 64'(DEPTH));
    assign acc_idx      = IDX_W'(acc_addr);
    assign mem_we       = acc_go & acc_wr & acc_in_range;
    assign rd_go        = acc_go & ~acc_wr;

    // State, counters, request latch and read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            ready      <= (CLEAR_ON_RESET == 0);
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            lat_addr_q <= '0;
            lat_wr_q   <= 1'b0;
            lat_data_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready      <= ready_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lat_addr_q <= lat_addr_d;
            lat_wr_q   <= lat_wr_d;
            lat_data_q <= lat_data_d;
            if (rd_go) begin
                rd_data_q <= acc_in_range ? mem[acc_idx] : '0;
            end
        end
    end

    // Storage array; reset blocks any write so a pending access is aborted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_cnt_q] <= '0;
            end else if (mem_we) begin
                mem[acc_idx] <= acc_data;
            end
        end
    end

`ifdef BUS_MEMORY_PARITY_EN
    // Even parity per word, checked when a read completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem_par[clr_cnt_q] <= 1'b0;
            end else if (mem_we) begin
                mem_par[acc_idx] <= ^acc_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_go & acc_in_range &
                          ((^mem[acc_idx]) != mem_par[acc_idx]);
        end
    end
`endif

    // Tri-state bus driver.
    assign data_out = output_en ? rd_data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_memory_wait.sv
// tb_bus_memory_wait: directed bench for bus_memory_wait. Two instances share
// clk/reset: u_w0 (DEPTH=16, no wait states) and u_w3 (DEPTH=16, 3 wait
// states). Inputs are driven and outputs sampled on the falling edge.
module tb_bus_memory_wait;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] addr0, din0;
    logic        rw0, en0, oe0;
    wire  [15:0] dout0;
    wire         rdy0;

    logic [15:0] addr1, din1;
    logic        rw1, en1, oe1;
    wire  [15:0] dout1;
    wire         rdy1;

`ifdef BUS_MEMORY_PARITY_EN
    wire         perr0, perr1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_memory_wait #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(16),
        .WAIT_STATES(0), .CLEAR_ON_RESET(1)
    ) u_w0 (
        .clk(clk), .reset(reset), .address(addr0), .read_write(rw0),
        .enable(en0), .output_en(oe0), .data_in(din0), .data_out(dout0),
`ifdef BUS_MEMORY_PARITY_EN
        .parity_err(perr0),
`endif
        .ready(rdy0)
    );

    bus_memory_wait #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(16),
        .WAIT_STATES(3), .CLEAR_ON_RESET(1)
    ) u_w3 (
        .clk(clk), .reset(reset), .address(addr1), .read_write(rw1),
        .enable(en1), .output_en(oe1), .data_in(din1), .data_out(dout1),
`ifdef BUS_MEMORY_PARITY_EN
        .parity_err(perr1),
`endif
        .ready(rdy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Single access on the zero-wait instance; returns data_out one cycle later.
    task automatic acc0(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rdata);
        rw0 = wr; addr0 = a; din0 = d; en0 = 1'b1;
        @(negedge clk);
        en0 = 1'b0;
        check("w0_ready_high", 32'(rdy0), 32'd1);
        rdata = dout0;
    endtask

    // Single access on the 3-wait instance; returns read data and low-ready cycles.
    task automatic acc1(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rdata, output int low);
        int guard;
        guard = 0;
        while (!rdy1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy1) check("w3_idle_timeout", 32'(rdy1), 32'd1);
        rw1 = wr; addr1 = a; din1 = d; en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        low = 0;
        while (!rdy1 && low < 100) begin
            low++;
            @(negedge clk);
        end
        if (!rdy1) check("w3_done_timeout", 32'(rdy1), 32'd1);
        rdata = dout1;
    endtask

    // Counts cycles from reset release until ready rises on both instances.
    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (rdy0) break;
        end
        check(tag, 32'(cnt), 32'd16);
        check({tag, "_w3"}, 32'(rdy1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        int          low;

        reset = 1'b1;
        addr0 = '0; din0 = '0; rw0 = 1'b0; en0 = 1'b0; oe0 = 1'b1;
        addr1 = '0; din1 = '0; rw1 = 1'b0; en1 = 1'b0; oe1 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready_w0", 32'(rdy0), 32'd0);
        check("rst_ready_w3", 32'(rdy1), 32'd0);
        check("rst_dout_w0", 32'(dout0), 32'h0000);
`ifdef BUS_MEMORY_PARITY_EN
        check("rst_perr_w0", 32'(perr0), 32'd0);
`endif

        // Clear sweep: ready low for exactly DEPTH cycles after release
        reset = 1'b0;
        wait_clear("clear_cycles");
        for (int i = 0; i < 16; i++) begin
            acc0(1'b0, 16'(i), 16'h0, r);
            check($sformatf("clear_word_%0d", i), 32'(r), 32'h0000);
        end

        // Zero wait states: back-to-back write then read
        acc0(1'b1, 16'd5, 16'hBEEF, r);
        acc0(1'b0, 16'd5, 16'h0, r);
        check("w0_read_beef", 32'(r), 32'hBEEF);
        acc0(1'b1, 16'd6, 16'h1111, r);
        check("w0_write_keeps_rd", 32'(r), 32'hBEEF);
        acc0(1'b0, 16'd6, 16'h0, r);
        check("w0_read_1111", 32'(r), 32'h1111);

        // Three wait states: write 0x1234 @2 with ignored enable pulses to @9
        rw1 = 1'b1; addr1 = 16'd2; din1 = 16'h1234; en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        low = 0;
        while (!rdy1 && low < 20) begin
            low++;
            rw1 = 1'b1; addr1 = 16'd9; din1 = 16'hDEAD; en1 = 1'b1;
            @(negedge clk);
        end
        en1 = 1'b0;
        check("w3_write_low_cycles", 32'(low), 32'd3);

        // Read @2: data appears at the 4th edge counting the accept edge
        rw1 = 1'b0; addr1 = 16'd2; en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        check("w3_rd_edge1", 32'(dout1), 32'h0000);
        @(negedge clk);
        @(negedge clk);
        check("w3_rd_edge3", 32'(dout1), 32'h0000);
        check("w3_rd_edge3_busy", 32'(rdy1), 32'd0);
        @(negedge clk);
        check("w3_rd_edge4", 32'(dout1), 32'h1234);
        check("w3_rd_edge4_ready", 32'(rdy1), 32'd1);

        acc1(1'b0, 16'd9, 16'h0, r, low);
        check("w3_pulse_ignored", 32'(r), 32'h0000);

        // Out of range
        acc1(1'b1, 16'h0010, 16'hAAAA, r, low);
        check("oor_write_low", 32'(low), 32'd3);
        acc1(1'b0, 16'd0, 16'h0, r, low);
        check("oor_word0_unchanged", 32'(r), 32'h0000);
        acc1(1'b0, 16'd2, 16'h0, r, low);
        check("oor_pre_read", 32'(r), 32'h1234);
        acc1(1'b0, 16'h0010, 16'h0, r, low);
        check("oor_read_zero", 32'(r), 32'h0000);
        check("oor_read_low", 32'(low), 32'd3);

        // Output enable gating
        acc1(1'b1, 16'd4, 16'h5A5A, r, low);
        acc1(1'b0, 16'd4, 16'h0, r, low);
        check("oe_read", 32'(r), 32'h5A5A);
        oe1 = 1'b0;
        #1;
        check("oe_off_not_driving", 32'(dout1 === 16'h5A5A), 32'd0);
        @(negedge clk);
        oe1 = 1'b1;
        #1;
        check("oe_on_again", 32'(dout1), 32'h5A5A);

        // Reset during WAIT of a write 0xFFFF @7
        @(negedge clk);
        rw1 = 1'b1; addr1 = 16'd7; din1 = 16'hFFFF; en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        check("mid_wait_busy", 32'(rdy1), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_wait_rst_dout", 32'(dout1), 32'h0000);
        wait_clear("reclear_cycles");
        acc1(1'b0, 16'd7, 16'h0, r, low);
        check("aborted_write_word7", 32'(r), 32'h0000);

`ifdef BUS_MEMORY_PARITY_EN
        // Parity: corrupt stored bit 0 of word 3, then read it
        acc0(1'b1, 16'd3, 16'h0001, r);
        u_w0.mem[3] = u_w0.mem[3] ^ 16'h0001;
        rw0 = 1'b0; addr0 = 16'd3; en0 = 1'b1;
        @(negedge clk);
        en0 = 1'b0;
        check("perr_flagged", 32'(perr0), 32'd1);
        @(negedge clk);
        check("perr_one_cycle", 32'(perr0), 32'd0);
        acc0(1'b1, 16'd4, 16'h0003, r);
        acc0(1'b0, 16'd4, 16'h0, r);
        check("perr_clean_read", 32'(perr0), 32'd0);
        acc0(1'b0, 16'h0010, 16'h0, r);
        check("perr_oor_read", 32'(perr0), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_memory_wait.md
Name: bus_memory_wait

Overview:
- Parametrised single-port synchronous RAM for the shared 16-bit system bus. Successor to the fixed 16-bit bus memory.
- Adds configurable data width, address width and depth.
- Adds programmable wait states with a ready handshake, a post-reset clear sweep, and a tri-state read-data driver.
- Sits on the bus between the CPU/stimulus master and the shared data bus.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 16, address bus width.
- DEPTH, 1024, number of words implemented; must be 1..2^ADDR_WIDTH.
- WAIT_STATES, 0, extra cycles per access (0..255).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the sweep.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  word address, sampled on accept.
- read_write  input  1  1 = write, 0 = read; sampled on accept.
- enable  input  1  access request.
- output_en  input  1  drives data_out when high.
- data_in  input  DATA_WIDTH  write data, sampled on accept.
- data_out  output  DATA_WIDTH  read-data register when output_en = 1, else high-Z.
- ready  output  1  high = idle and able to accept a request.

Behaviour:
- States: CLEAR, IDLE, WAIT.
- Reset (sampled high on a clk edge):
  - state <= CLEAR, or IDLE if CLEAR_ON_RESET = 0.
  - clear counter <= 0, wait counter <= 0, read register <= 0.
  - ready = 0 while in CLEAR.
  - Any pending write is aborted and never committed.
- CLEAR: writes 0 to word[clear counter] each cycle, counter +1. At the edge that writes word DEPTH-1, go to IDLE. ready rises exactly DEPTH cycles after reset is released.
- IDLE: ready = 1. Accept = enable & ready on a clk edge; address, read_write and data_in are latched at that edge.
  - WAIT_STATES = 0: access performed at the accept edge; state stays IDLE; ready stays 1. Back-to-back accesses every cycle are legal.
  - WAIT_STATES = W > 0: go to WAIT, wait counter <= W-1, ready = 0.
- WAIT: counter decrements each edge. At the edge where the counter is 0, the latched access is performed and state returns to IDLE. ready is low for exactly W cycles per access.
- enable while ready = 0 is ignored and not queued. Inputs that change during WAIT have no effect.
- Write: word[addr] <= latched data; the read register is unchanged.
- Read: read register <= word[addr]. It holds that value until the next completed read or reset.
- Out of range (addr >= DEPTH): write is dropped; read loads 0. Timing is unchanged.
- data_out: combinational from output_en (outside the clocked logic). Value is the read register or {DATA_WIDTH{1'bz}}. No internal bus-contention check.
- Reset asserted mid-WAIT or mid-CLEAR takes priority over everything and restarts per the rules above.

Optional Feature:
- BUS_MEMORY_PARITY_EN defined:
  - Each word is stored with one extra even-parity bit, computed on data_in at write and zero during CLEAR.
  - Extra output port parity_err (1 bit, reset 0). It pulses high for one cycle after a read completes when the stored parity mismatches the stored data.
  - Out-of-range reads never flag.
- Undefined: no parity storage and no parity_err port. Behaviour is otherwise identical.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1: hold reset 3 cycles, release -> ready stays 0 for exactly 16 cycles, then 1. Reads of addr 0..15 return 0x0000.
- WAIT_STATES=0: write 0xBEEF @5, next cycle read @5, output_en=1 -> data_out = 0xBEEF one cycle after read accept; ready never drops.
- WAIT_STATES=3: write 0x1234 @2 -> ready low 3 cycles. Read @2 -> data_out = 0x1234 after the 4th edge from accept. enable pulses during WAIT are ignored (the word at the pulsed address is unchanged).
- DEPTH=16, ADDR_WIDTH=16: write 0xAAAA @0x0010 -> word 0 unchanged. Read @0x0010 -> 0x0000. Read timing is identical to an in-range access.
- output_en=0 after a read of 0x5A5A -> data_out all Z. Raise output_en -> 0x5A5A without a new access. Reset asserted during WAIT of a write 0xFFFF @7 -> after the clear sweep, word 7 = 0.
- BUS_MEMORY_PARITY_EN: write 0x0001 @3, force-flip the stored bit 0, read @3 -> parity_err = 1 for exactly one cycle. Read of an unflipped word -> parity_err stays 0.
